// File: rtl/shift_row_serial.sv
// Byte-serial forward AES ShiftRows: buffers a column-major 16-byte state,
// then replays it in ShiftRows order over a second valid/ready stream.
module shift_row_serial #(
  parameter int BYTES = 16,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam logic [0:0]       FILL     = 1'b0;
  localparam logic [0:0]       DRAIN    = 1'b1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [7:0]       buf_q [BYTES];

  logic             in_fire;
  logic             out_fire;
  logic [1:0]       out_row;
  logic [1:0]       out_col;
  logic [1:0]       src_col;
  logic [CNT_W-1:0] src_idx;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == DRAIN);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Output byte r+4c comes from row r of column (c+r) mod 4; the 2-bit add wraps.
  assign out_row = out_cnt_q[1:0];
  assign out_col = out_cnt_q[3:2];
  assign src_col = out_col + out_row;
  assign src_idx = {src_col, out_row};

  assign out_data = buf_q[src_idx];
  assign out_last = (state_q == DRAIN) && (out_cnt_q == LAST_IDX);
  assign busy     = !((state_q == FILL) && (in_cnt_q == '0));

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    if (flush) begin
      state_d   = FILL;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_fire) begin
            in_cnt_d = in_cnt_q + CNT_ONE;
            if (in_cnt_q == LAST_IDX) begin
              in_cnt_d = '0;
              state_d  = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            out_cnt_d = out_cnt_q + CNT_ONE;
            if (out_cnt_q == LAST_IDX) begin
              out_cnt_d = '0;
              state_d   = FILL;
            end
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Buffer has no reset; a byte arriving with flush or reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && !flush && in_fire) begin
      buf_q[in_cnt_q] <= in_data;
    end
  end

endmodule
